dac_replay_buf: RTL and testbench



---
 rtl/dac_replay_pkg.sv | 13 +
 rtl/dac_replay_ram.sv | 22 ++
 rtl/dac_replay_buf.sv | 134 +++++++++++++
 tb/tb_dac_replay_buf.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_replay_pkg.sv
// dac_replay_pkg: state and mode encodings shared by the DAC replay buffer
package dac_replay_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FILL,
        ST_CAPTURE,
        ST_PLAY,
        ST_PASS
    } state_e;
    localparam logic [1:0] MODE_LOOP    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_PASS    = 2'd2;
endpackage

// File: rtl/dac_replay_ram.sv
// dac_replay_ram: simple dual-port replay store with a registered read port
module dac_replay_ram
    import dac_replay_pkg::*;
#(
    parameter int W     = 48,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    // one write port and one registered read, no reset so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/dac_replay_buf.sv
// dac_replay_buf: captures a block of FIFO words into RAM and replays it (loop/one-shot) or passes FIFO data straight through
module dac_replay_buf
    import dac_replay_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int LANES  = 4,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 14
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [1:0]                mode,
    input  logic [$clog2(DEPTH):0]    play_len,
    input  logic [CNT_W-1:0]          fifo_rd_cnt,
    input  logic                      fifo_empty,
    input  logic [LANES*DATA_W-1:0]   fifo_rd_data,
    output logic                      fifo_rd_en,
    output logic [LANES*DATA_W-1:0]   dac_data,
    output logic                      dac_valid,
    output logic                      capture_done,
    output logic                      busy
);
    localparam int W  = LANES * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_e        state_q, state_d;
    logic [1:0]    mode_q;
    logic [LW-1:0] len_q, len_in, issued_q, wr_cnt_q, rd_cnt_q;
    logic [AW-1:0] rd_addr_q;
    logic          pend_q, play_vld_q, ram_we, play_issue, last_wr, pass_vld;
    logic [W-1:0]  ram_rdata;

    assign len_in   = (play_len == '0 || 32'(play_len) > DEPTH) ? LW'(DEPTH) : play_len;
    assign last_wr  = pend_q && wr_cnt_q == len_q - LW'(1);
    assign pass_vld = pend_q && state_q == ST_PASS;
    assign busy     = state_q != ST_IDLE;
    assign dac_valid = play_vld_q | pass_vld;
    assign dac_data  = play_vld_q ? ram_rdata : (pass_vld ? fifo_rd_data : '0);

    // next state and per-cycle strobes; stop and reset override everything
    always_comb begin
        state_d      = state_q;
        fifo_rd_en   = 1'b0;
        capture_done = 1'b0;
        ram_we       = 1'b0;
        play_issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_PASS) state_d = ST_PASS;
                    else state_d = ST_WAIT_FILL;
                end
            end
            ST_WAIT_FILL: begin
                if (32'(fifo_rd_cnt) >= 32'(len_q)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                fifo_rd_en   = !fifo_empty && issued_q < len_q;
                ram_we       = pend_q;
                capture_done = last_wr;
                if (last_wr) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                play_issue = !(mode_q == MODE_ONESHOT && rd_cnt_q == len_q);
                if (!play_issue) state_d = ST_IDLE;
            end
            ST_PASS: fifo_rd_en = !fifo_empty;
            default: state_d = ST_IDLE;
        endcase
        if (stop || rd_rst) begin
            state_d      = ST_IDLE;
            fifo_rd_en   = 1'b0;
            capture_done = 1'b0;
            ram_we       = 1'b0;
            play_issue   = 1'b0;
        end
    end

    // state register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // start-time latches, capture/replay counters and output-valid pipeline
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            mode_q     <= MODE_LOOP;
            len_q      <= LW'(DEPTH);
            issued_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            pend_q     <= 1'b0;
            play_vld_q <= 1'b0;
        end else begin
            pend_q     <= fifo_rd_en;
            play_vld_q <= play_issue;
            if (state_q == ST_IDLE) begin
                issued_q  <= '0;
                wr_cnt_q  <= '0;
                rd_cnt_q  <= '0;
                rd_addr_q <= '0;
                if (start && !stop) begin
                    mode_q <= mode;
                    len_q  <= len_in;
                end
            end else begin
                issued_q <= issued_q + LW'(fifo_rd_en);
                wr_cnt_q <= wr_cnt_q + LW'(ram_we);
                if (play_issue) begin
                    rd_cnt_q  <= rd_cnt_q + LW'(rd_cnt_q != len_q);
                    rd_addr_q <= ({1'b0, rd_addr_q} == len_q - LW'(1)) ? '0 : rd_addr_q + AW'(1);
                end
            end
        end
    end

    dac_replay_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (rd_clk),
        .we_i    (ram_we),
        .waddr_i (wr_cnt_q[AW-1:0]),
        .wdata_i (fifo_rd_data),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_dac_replay_buf.sv
// tb_dac_replay_buf: directed/randomized checks of capture, replay, pass-through, stop and reset
module tb_dac_replay_buf;
    import dac_replay_pkg::*;
    localparam int DATA_W = 12;
    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 14;
    localparam int W      = LANES * DATA_W;
    localparam int LW     = $clog2(DEPTH) + 1;
    typedef logic [W-1:0] word_t;

    logic             rd_clk = 1'b0;
    logic             rd_rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [LW-1:0]    play_len = '0;
    logic [CNT_W-1:0] fifo_rd_cnt = '0;
    logic             fifo_empty = 1'b1;
    word_t            fifo_rd_data = '0;
    logic             fifo_rd_en, dac_valid, capture_done, busy;
    word_t            dac_data;

    int    checks = 0;
    int    errors = 0;
    word_t fq[$];
    word_t exp_w[$];
    word_t pass_exp[$];
    bit    cnt_hold = 0;
    bit    tog_en = 0;
    bit    tog_q = 0;
    int    cnt_val = 0;

    dac_replay_buf #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .play_len     (play_len),
        .fifo_rd_cnt  (fifo_rd_cnt),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .dac_data     (dac_data),
        .dac_valid    (dac_valid),
        .capture_done (capture_done),
        .busy         (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // upstream FIFO model: one-cycle read latency, registered occupancy/empty, optional empty toggling
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            checks++;
            assert (!fifo_empty && fq.size() > 0) else begin
                errors++;
                $error("FAIL rd_en_while_empty obs=1 exp=0");
            end
            if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
        end
        tog_q       <= tog_en && !tog_q;
        fifo_empty  <= fq.size() == 0 || (tog_en && !tog_q);
        fifo_rd_cnt <= cnt_hold ? CNT_W'(cnt_val) : CNT_W'(fq.size());
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge rd_clk);
    endtask

    task automatic load(input int n);
        word_t w;
        exp_w.delete();
        for (int i = 0; i < n; i++) begin
            w = word_t'({$urandom(), $urandom()});
            exp_w.push_back(w);
            fq.push_back(w);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [LW-1:0] l);
        mode = m;
        play_len = l;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cyc();
            seen = capture_done;
        end
        chk("capture_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_play(input int len, input int n, input bit oneshot, input bit poke);
        cyc();
        chk("play_first_latency", 64'(dac_valid), 64'd0);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("play_valid", 64'(dac_valid), 64'd1);
            chk("play_data", 64'(dac_data), 64'(exp_w[i % len]));
            chk("capture_done_once", 64'(capture_done), 64'd0);
            start = 1'b0;
            if (poke && i == 3) begin
                start = 1'b1;
                mode = MODE_PASS;
                play_len = LW'(3);
            end
        end
        start = 1'b0;
        if (oneshot) begin
            cyc();
            chk("oneshot_end_valid", 64'(dac_valid), 64'd0);
            chk("oneshot_end_data", 64'(dac_data), 64'd0);
            chk("oneshot_end_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(dac_valid), 64'd0);
        chk({tag, "_data"}, 64'(dac_data), 64'd0);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_capdone"}, 64'(capture_done), 64'd0);
    endtask

    task automatic stop_check(input string tag);
        stop = 1'b1;
        #1;
        chk({tag, "_stop_rd_en"}, 64'(fifo_rd_en), 64'd0);
        cyc();
        stop = 1'b0;
        idle_check(tag);
    endtask

    initial begin
        bit    seen;
        bit    prev;
        word_t w;
        repeat (3) cyc();
        idle_check("reset");
        rd_rst = 1'b0;
        cyc();
        // loop, words 1..8, with an ignored start mid-play
        exp_w.delete();
        for (int i = 1; i <= 8; i++) begin
            exp_w.push_back(word_t'(i));
            fq.push_back(word_t'(i));
        end
        pulse_start(MODE_LOOP, LW'(8));
        wait_done();
        run_play(8, 20, 0, 1);
        stop_check("loop_stop");
        // one-shot of four random words
        load(4);
        pulse_start(MODE_ONESHOT, LW'(4));
        wait_done();
        run_play(4, 4, 1, 0);
        // occupancy below length holds in WAIT_FILL
        cnt_hold = 1;
        cnt_val = 3;
        load(5);
        pulse_start(MODE_LOOP, LW'(5));
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("wait_fill_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("wait_fill_busy", 64'(busy), 64'd1);
        end
        cnt_hold = 0;
        wait_done();
        run_play(5, 10, 0, 0);
        stop_check("wait_fill_stop");
        // empty flag toggling during capture
        tog_en = 1;
        load(6);
        pulse_start(MODE_LOOP, LW'(6));
        wait_done();
        tog_en = 0;
        run_play(6, 12, 0, 0);
        stop_check("toggle_stop");
        // pass-through
        pass_exp.delete();
        for (int i = 0; i < 3; i++) begin
            fq.push_back(48'h123123123123);
            pass_exp.push_back(48'h123123123123);
        end
        pulse_start(MODE_PASS, LW'(0));
        prev = 0;
        for (int i = 0; i < 24; i++) begin
            if (prev) begin
                chk("pass_valid", 64'(dac_valid), 64'd1);
                chk("pass_data", 64'(dac_data), 64'(pass_exp.pop_front()));
            end else begin
                chk("pass_idle_valid", 64'(dac_valid), 64'd0);
                chk("pass_idle_data", 64'(dac_data), 64'd0);
            end
            if ($urandom_range(1) == 1) begin
                w = (i < 8) ? 48'h123123123123 : word_t'({$urandom(), $urandom()});
                fq.push_back(w);
                pass_exp.push_back(w);
            end
            prev = fifo_rd_en;
            cyc();
        end
        stop_check("pass_stop");
        fq.delete();
        // reset in the middle of capture, then recapture from address 0
        load(8);
        pulse_start(MODE_LOOP, LW'(8));
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cyc();
            seen = fifo_rd_en;
        end
        chk("capture_started", 64'(seen), 64'd1);
        cyc();
        rd_rst = 1'b1;
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        cyc();
        rd_rst = 1'b0;
        idle_check("rst_capture");
        fq.delete();
        load(3);
        pulse_start(MODE_LOOP, LW'(3));
        wait_done();
        run_play(3, 9, 0, 0);
        stop_check("recapture_stop");
        // length 0 and length above DEPTH both mean DEPTH
        load(DEPTH);
        pulse_start(MODE_ONESHOT, LW'(0));
        wait_done();
        run_play(DEPTH, DEPTH, 1, 0);
        load(DEPTH);
        pulse_start(MODE_ONESHOT, LW'(20));
        wait_done();
        run_play(DEPTH, DEPTH, 1, 0);
        // reserved mode replays as loop
        load(3);
        pulse_start(2'd3, LW'(3));
        wait_done();
        run_play(3, 10, 0, 0);
        stop_check("reserved_stop");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
